imem_boot_loader: RTL and testbench

- Upstream stage of the 8-bit single-cycle processor: fills the 8-bit-wide instruction memory from a byte stream before the core runs.
- Accepts a framed stream (length byte, program bytes, checksum byte) over a valid/ready handshake.
- Writes the program bytes sequentially from address 0 and releases the core from reset only after a verified load.

---
 rtl/imem_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader for the 8-bit core: takes a length/program/checksum frame and copies the
// program into instruction memory from address 0, releasing the core only on a verified load.
module imem_boot_loader #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       imem_we,
    output logic [7:0] imem_addr,
    output logic [7:0] imem_wdata,
    output logic       cpu_run,
    output logic       load_done,
    output logic       load_err,
    output logic [7:0] byte_count
);

    localparam int            IW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);
    localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_len;
    logic [7:0]    r_checksum;
    logic [7:0]    r_byte_count;
    logic [7:0]    r_addr;
    logic [7:0]    r_wdata;
    logic          r_we;
    logic [IW-1:0] r_idle;

    logic          w_ready;
    logic          w_accept;
    logic          w_len_bad;
    logic          w_last_byte;
    logic          w_timeout;
    logic [IW-1:0] w_idle_inc;
    logic [7:0]    w_count_inc;

    assign w_accept    = in_valid & w_ready;
    assign w_len_bad   = (in_data == 8'd0) || (in_data > DEPTH_B);
    assign w_count_inc = r_byte_count + 8'd1;
    assign w_last_byte = (w_count_inc == r_len);
    assign w_idle_inc  = r_idle + 1'b1;
    assign w_timeout   = (w_idle_inc == TIMEOUT_C);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An accept always wins over a timeout landing on the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN: begin
                if (w_accept) begin
                    w_state_next = w_len_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (w_last_byte) begin
                        w_state_next = S_CSUM;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_next = (in_data == r_checksum) ? S_DONE : S_ERROR;
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        load_done = 1'b0;
        cpu_run   = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            S_LEN, S_DATA, S_CSUM: w_ready = 1'b1;
            S_DONE: begin
                load_done = 1'b1;
                cpu_run   = 1'b1;
            end
            S_ERROR: load_err = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Write pulse, address and data are registered, so each byte lands one cycle after its accept.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_we         <= 1'b0;
            r_addr       <= 8'd0;
            r_wdata      <= 8'd0;
            r_len        <= 8'd0;
            r_checksum   <= 8'd0;
            r_byte_count <= 8'd0;
            r_idle       <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        r_len        <= in_data;
                        r_checksum   <= 8'd0;
                        r_byte_count <= 8'd0;
                        r_idle       <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_we         <= 1'b1;
                        r_addr       <= r_byte_count;
                        r_wdata      <= in_data;
                        r_byte_count <= w_count_inc;
                        r_checksum   <= r_checksum + in_data;
                        r_idle       <= '0;
                    end else begin
                        r_idle <= w_idle_inc;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_idle <= '0;
                    end else begin
                        r_idle <= w_idle_inc;
                    end
                end
                default: begin
                    r_idle <= r_idle;
                end
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: a frame-level model predicts every output
// each cycle, directed frames pin literal results, and random frames stress the handshake.
module tb_imem_boot_loader;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 255;

    logic       clock;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_run;
    logic       load_done;
    logic       load_err;
    logic [7:0] byte_count;

    imem_boot_loader #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err),
        .byte_count(byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit cmpEn  = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t wrLog[$];

    // Frame-level model: what has been received so far decides every output.
    bit         mHaveLen = 1'b0;
    bit         mDone    = 1'b0;
    bit         mErr     = 1'b0;
    bit         mWe      = 1'b0;
    int         mLen     = 0;
    int         mBytes   = 0;
    int         mIdle    = 0;
    int         mSum     = 0;
    logic [7:0] mAddr    = 8'd0;
    logic [7:0] mWdata   = 8'd0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock) begin
        cycle++;
        if (!reset) begin
            mHaveLen = 1'b0;
            mDone    = 1'b0;
            mErr     = 1'b0;
            mWe      = 1'b0;
            mLen     = 0;
            mBytes   = 0;
            mIdle    = 0;
            mSum     = 0;
            mAddr    = 8'd0;
            mWdata   = 8'd0;
        end else begin
            mWe = 1'b0;
            if (!(mDone || mErr)) begin
                if (!mHaveLen) begin
                    if (in_valid) begin
                        mLen = int'(in_data);
                        if (mLen == 0 || mLen > DEPTH) begin
                            mErr = 1'b1;
                        end else begin
                            mHaveLen = 1'b1;
                            mBytes   = 0;
                            mSum     = 0;
                            mIdle    = 0;
                        end
                    end
                end else if (in_valid) begin
                    mIdle = 0;
                    if (mBytes < mLen) begin
                        mWe    = 1'b1;
                        mAddr  = 8'(mBytes);
                        mWdata = in_data;
                        mSum   = (mSum + int'(in_data)) % 256;
                        mBytes++;
                    end else if (int'(in_data) == mSum) begin
                        mDone = 1'b1;
                    end else begin
                        mErr = 1'b1;
                    end
                end else begin
                    mIdle++;
                    if (mIdle >= TIMEOUT) mErr = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmpEn) begin
            checkOutput("cyc in_ready", 16'(in_ready), 16'(!(mDone || mErr)));
            checkOutput("cyc load_done", 16'(load_done), 16'(mDone));
            checkOutput("cyc cpu_run", 16'(cpu_run), 16'(mDone));
            checkOutput("cyc load_err", 16'(load_err), 16'(mErr));
            checkOutput("cyc byte_count", 16'(byte_count), 16'(mBytes));
            checkOutput("cyc imem_we", 16'(imem_we), 16'(mWe));
            if (mWe) begin
                checkOutput("cyc imem_addr", 16'(imem_addr), 16'(mAddr));
                checkOutput("cyc imem_wdata", 16'(imem_wdata), 16'(mWdata));
            end
        end
        if (imem_we === 1'b1) wrLog.push_back('{cycle, imem_addr, imem_wdata});
    end

    task automatic applyStimulus(input logic rstn, input logic valid, input logic [7:0] data);
        reset    = rstn;
        in_valid = valid;
        in_data  = data;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 8'($urandom));
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'($urandom), 8'($urandom));
        wrLog.delete();
        cmpEn = 1'b1;
    endtask

    task automatic checkWrite(input string name, input int idx, input logic [7:0] addr, input logic [7:0] data);
        if (idx >= wrLog.size()) begin
            checkOutput({name, " present"}, 16'(wrLog.size()), 16'(idx + 1));
        end else begin
            checkOutput({name, " addr"}, 16'(wrLog[idx].addr), 16'(addr));
            checkOutput({name, " data"}, 16'(wrLog[idx].data), 16'(data));
        end
    endtask

    int         len;
    int         nSend;
    int         abortAt;
    int         sum;
    logic [7:0] b;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(negedge clock);
        #1;

        // Reset values
        doReset();
        checkOutput("reset in_ready", 16'(in_ready), 16'd1);
        checkOutput("reset imem_we", 16'(imem_we), 16'd0);
        checkOutput("reset imem_addr", 16'(imem_addr), 16'd0);
        checkOutput("reset imem_wdata", 16'(imem_wdata), 16'd0);
        checkOutput("reset cpu_run", 16'(cpu_run), 16'd0);
        checkOutput("reset load_done", 16'(load_done), 16'd0);
        checkOutput("reset load_err", 16'(load_err), 16'd0);
        checkOutput("reset byte_count", 16'(byte_count), 16'd0);

        // Normal load
        sendByte(8'h03); sendByte(8'h21); sendByte(8'h4A); sendByte(8'h83); sendByte(8'hEE);
        checkOutput("normal nwrites", 16'(wrLog.size()), 16'd3);
        checkWrite("normal w0", 0, 8'd0, 8'h21);
        checkWrite("normal w1", 1, 8'd1, 8'h4A);
        checkWrite("normal w2", 2, 8'd2, 8'h83);
        if (wrLog.size() == 3) checkOutput("normal back-to-back", 16'(wrLog[2].cyc - wrLog[0].cyc), 16'd2);
        checkOutput("normal load_done", 16'(load_done), 16'd1);
        checkOutput("normal cpu_run", 16'(cpu_run), 16'd1);
        checkOutput("normal byte_count", 16'(byte_count), 16'd3);
        checkOutput("normal in_ready", 16'(in_ready), 16'd0);
        sendByte(8'h55); idleCycle();
        checkOutput("done holds count", 16'(byte_count), 16'd3);
        checkOutput("done no write", 16'(wrLog.size()), 16'd3);

        // Bad checksum
        doReset();
        sendByte(8'h03); sendByte(8'h21); sendByte(8'h4A); sendByte(8'h83); sendByte(8'hEF);
        checkOutput("badsum nwrites", 16'(wrLog.size()), 16'd3);
        checkOutput("badsum load_err", 16'(load_err), 16'd1);
        checkOutput("badsum cpu_run", 16'(cpu_run), 16'd0);
        checkOutput("badsum load_done", 16'(load_done), 16'd0);

        // Illegal lengths
        doReset();
        sendByte(8'h00);
        checkOutput("len0 load_err", 16'(load_err), 16'd1);
        checkOutput("len0 byte_count", 16'(byte_count), 16'd0);
        sendByte(8'h12);
        checkOutput("len0 nwrites", 16'(wrLog.size()), 16'd0);
        doReset();
        sendByte(8'h21);
        checkOutput("len33 load_err", 16'(load_err), 16'd1);
        checkOutput("len33 in_ready", 16'(in_ready), 16'd0);
        sendByte(8'h12);
        checkOutput("len33 nwrites", 16'(wrLog.size()), 16'd0);

        // Throttled source with checksum wrap
        doReset();
        sendByte(8'h02); sendByte(8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h78);
        sendByte(8'h02); sendByte(8'h01);
        checkOutput("throttle nwrites", 16'(wrLog.size()), 16'd2);
        checkWrite("throttle w0", 0, 8'd0, 8'hFF);
        checkWrite("throttle w1", 1, 8'd1, 8'h02);
        checkOutput("throttle load_done", 16'(load_done), 16'd1);

        // Timeout fires exactly at 255 idle cycles
        doReset();
        sendByte(8'h04); sendByte(8'h10);
        for (int k = 1; k <= 255; k++) begin
            idleCycle();
            if (k == 254) checkOutput("timeout early", 16'(load_err), 16'd0);
        end
        checkOutput("timeout load_err", 16'(load_err), 16'd1);
        checkOutput("timeout cpu_run", 16'(cpu_run), 16'd0);
        checkOutput("timeout byte_count", 16'(byte_count), 16'd1);
        checkOutput("timeout nwrites", 16'(wrLog.size()), 16'd1);
        checkWrite("timeout w0", 0, 8'd0, 8'h10);

        // Reset mid-load with a byte offered on the reset edge
        doReset();
        sendByte(8'h05); sendByte(8'h11); sendByte(8'h22);
        applyStimulus(1'b0, 1'b1, 8'h33);
        wrLog.delete();
        checkOutput("midrst imem_we", 16'(imem_we), 16'd0);
        checkOutput("midrst byte_count", 16'(byte_count), 16'd0);
        checkOutput("midrst in_ready", 16'(in_ready), 16'd1);
        checkOutput("midrst imem_addr", 16'(imem_addr), 16'd0);
        sendByte(8'h02); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h65);
        checkWrite("midrst w0", 0, 8'd0, 8'hAA);
        checkWrite("midrst w1", 1, 8'd1, 8'hBB);
        checkOutput("midrst load_done", 16'(load_done), 16'd1);

        // Full-depth frame
        doReset();
        sendByte(8'(DEPTH));
        sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            sum += int'(b);
            sendByte(b);
        end
        sendByte(8'(sum));
        checkOutput("full nwrites", 16'(wrLog.size()), 16'(DEPTH));
        if (wrLog.size() == DEPTH) checkOutput("full last addr", 16'(wrLog[DEPTH-1].addr), 16'(DEPTH - 1));
        checkOutput("full load_done", 16'(load_done), 16'd1);

        // Random frames, checked by the model every cycle
        for (int f = 0; f < 40; f++) begin
            doReset();
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(DEPTH + 1, 255);
                default: len = $urandom_range(1, DEPTH);
            endcase
            sendByte(8'(len));
            nSend   = (len >= 1 && len <= DEPTH) ? len : 3;
            abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nSend) : -1;
            sum     = 0;
            for (int i = 0; i < nSend && i != abortAt; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) idleCycle();
                end
                b = 8'($urandom);
                sum += int'(b);
                sendByte(b);
            end
            if (abortAt < 0) begin
                if ($urandom_range(0, 3) == 0) sendByte(8'(sum + 1 + $urandom_range(0, 254)));
                else sendByte(8'(sum));
            end
            repeat (2) applyStimulus(1'b1, 1'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
